// File: rtl/bsg_decode_scoreboard_if.sv
// Request/status bundle for bsg_decode_scoreboard: set/clear requests in,
// registered sticky mask and its occupancy flags out.
interface bsg_decode_scoreboard_if #(
    parameter int num_out_p = 128
);
    localparam int lg_num_lp = $clog2(num_out_p);
    localparam int cnt_w_lp  = $clog2(num_out_p + 1);

    // Requests are single-cycle valid qualifiers with no ready: every valid
    // request is consumed on the clock edge where it is presented.
    logic                 set_v_i;
    logic [lg_num_lp-1:0] set_idx_i;
    logic                 clr_v_i;
    logic [lg_num_lp-1:0] clr_idx_i;
    logic                 clr_all_i;
    logic [num_out_p-1:0] mask_o;
    logic [cnt_w_lp-1:0]  count_o;
    logic                 empty_o;
    logic                 full_o;
    logic                 dup_o;
    logic                 err_o;

    modport master (
        output set_v_i, set_idx_i, clr_v_i, clr_idx_i, clr_all_i,
        input  mask_o, count_o, empty_o, full_o, dup_o, err_o
    );

    modport slave (
        input  set_v_i, set_idx_i, clr_v_i, clr_idx_i, clr_all_i,
        output mask_o, count_o, empty_o, full_o, dup_o, err_o
    );
endinterface

// File: rtl/bsg_decode_scoreboard.sv
// Sticky one-hot scoreboard: decodes one set and one clear index per cycle
// into a registered mask and keeps an incrementally maintained popcount.
module bsg_decode_scoreboard #(
    parameter int num_out_p = 128
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bsg_decode_scoreboard_if.slave sb_if
);
    localparam int lg_num_lp = $clog2(num_out_p);
    localparam int cnt_w_lp  = $clog2(num_out_p + 1);
    localparam logic [lg_num_lp:0]  limit_lp = (lg_num_lp + 1)'(num_out_p);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(num_out_p);

    logic [num_out_p-1:0] mask_q, mask_d, m1, m2;
    logic [cnt_w_lp-1:0]  count_q, count_d, cnt1;
    logic                 empty_q, full_q, dup_q, err_q, dup_d, err_d;
    logic                 set_in_range, clr_in_range, set_hit, clr_hit;

    always_comb begin
        set_in_range = ({1'b0, sb_if.set_idx_i} < limit_lp);
        clr_in_range = ({1'b0, sb_if.clr_idx_i} < limit_lp);

        m1   = sb_if.clr_all_i ? '0 : mask_q;
        cnt1 = sb_if.clr_all_i ? '0 : count_q;

        clr_hit = 1'b0;
        m2      = m1;
        if (sb_if.clr_v_i && clr_in_range) begin
            clr_hit                = m1[sb_if.clr_idx_i];
            m2[sb_if.clr_idx_i]    = 1'b0;
        end

        // The set is applied after the clear, so a set/clear pair on one
        // index leaves the bit set; dup looks at the post-clear mask.
        set_hit = 1'b0;
        dup_d   = 1'b0;
        mask_d  = m2;
        if (sb_if.set_v_i && set_in_range) begin
            set_hit                 = ~m2[sb_if.set_idx_i];
            dup_d                   = m2[sb_if.set_idx_i];
            mask_d[sb_if.set_idx_i] = 1'b1;
        end

        err_d   = (sb_if.set_v_i && !set_in_range) || (sb_if.clr_v_i && !clr_in_range);
        count_d = cnt1 - cnt_w_lp'(clr_hit) + cnt_w_lp'(set_hit);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mask_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            dup_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == full_cnt_lp);
            dup_q   <= dup_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (count_q == cnt_w_lp'($countones(mask_q)))
                else $error("count_o diverged from popcount of mask_o");
        end
    end

    assign sb_if.mask_o  = mask_q;
    assign sb_if.count_o = count_q;
    assign sb_if.empty_o = empty_q;
    assign sb_if.full_o  = full_q;
    assign sb_if.dup_o   = dup_q;
    assign sb_if.err_o   = err_q;
endmodule

// File: tb/tb_bsg_decode_scoreboard.sv
// Bench for bsg_decode_scoreboard: a 128-entry and a 100-entry instance driven
// with identical stimulus, checked against a bit-array reference model.
module tb_bsg_decode_scoreboard;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    bsg_decode_scoreboard_if #(.num_out_p(128)) if128 ();
    bsg_decode_scoreboard_if #(.num_out_p(100)) if100 ();

    bsg_decode_scoreboard #(.num_out_p(128)) dut128 (
        .clk_i   (clk),
        .reset_i (reset),
        .sb_if   (if128.slave)
    );

    bsg_decode_scoreboard #(.num_out_p(100)) dut100 (
        .clk_i   (clk),
        .reset_i (reset),
        .sb_if   (if100.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: mask as a plain bit array, count derived by popcount
    typedef struct {
        logic [127:0] mask;
        logic         dup;
        logic         err;
    } mstate_t;

    mstate_t m128, m100;

    function automatic mstate_t ref_step(int n, mstate_t s, logic rst, logic sv, int si,
                                         logic cv, int ci, logic ca);
        mstate_t r;
        r.mask = s.mask;
        r.dup  = 1'b0;
        r.err  = 1'b0;
        if (rst) begin
            r.mask = '0;
            return r;
        end
        if (ca) r.mask = '0;
        if (cv) begin
            if (ci < n) r.mask[ci] = 1'b0;
            else        r.err = 1'b1;
        end
        if (sv) begin
            if (si < n) begin
                r.dup = r.mask[si];
                r.mask[si] = 1'b1;
            end else begin
                r.err = 1'b1;
            end
        end
        return r;
    endfunction

    // scoreboard compare
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag, input int n, input mstate_t m,
                               input logic [127:0] mask, input int cnt, input logic emp,
                               input logic full, input logic dup, input logic err);
        int ecnt;
        ecnt = $countones(m.mask);
        chk({tag, "_mask"},  mask, m.mask);
        chk({tag, "_count"}, 128'(cnt), 128'(ecnt));
        chk({tag, "_empty"}, 128'(emp), 128'(ecnt == 0));
        chk({tag, "_full"},  128'(full), 128'(ecnt == n));
        chk({tag, "_dup"},   128'(dup), 128'(m.dup));
        chk({tag, "_err"},   128'(err), 128'(m.err));
    endtask

    // driver: one request cycle to both instances, then model compare
    task automatic step(input logic rst, input logic sv, input int si, input logic cv,
                        input int ci, input logic ca);
        reset           = rst;
        if128.set_v_i   = sv;
        if128.set_idx_i = 7'(si);
        if128.clr_v_i   = cv;
        if128.clr_idx_i = 7'(ci);
        if128.clr_all_i = ca;
        if100.set_v_i   = sv;
        if100.set_idx_i = 7'(si);
        if100.clr_v_i   = cv;
        if100.clr_idx_i = 7'(ci);
        if100.clr_all_i = ca;
        @(posedge clk);
        #1;
        m128 = ref_step(128, m128, rst, sv, si, cv, ci, ca);
        m100 = ref_step(100, m100, rst, sv, si, cv, ci, ca);
        check_model("d128", 128, m128, if128.mask_o, int'(if128.count_o), if128.empty_o,
                    if128.full_o, if128.dup_o, if128.err_o);
        check_model("d100", 100, m100, {28'b0, if100.mask_o}, int'(if100.count_o),
                    if100.empty_o, if100.full_o, if100.dup_o, if100.err_o);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    typedef struct {
        logic         rst;
        logic         sv;
        int           si;
        logic         cv;
        int           ci;
        logic         ca;
        logic [127:0] e_mask;
        int           e_cnt;
        logic         e_dup;
        logic         e_err100;
        int           e_cnt100;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [127:0] b127, b7, b9, b100;
        b127 = 128'h1 << 127;
        b7   = 128'h1 << 7;
        b9   = 128'h1 << 9;
        b100 = 128'h1 << 100;
        m128 = '{mask: '0, dup: 1'b0, err: 1'b0};
        m100 = '{mask: '0, dup: 1'b0, err: 1'b0};

        tbl[0]  = '{1'b0, 1'b1,   0, 1'b0,  0, 1'b0, 128'h1,        1, 1'b0, 1'b0, 1};
        tbl[1]  = '{1'b0, 1'b1, 127, 1'b0,  0, 1'b0, b127 | 128'h1, 2, 1'b0, 1'b1, 1};
        tbl[2]  = '{1'b0, 1'b0,   0, 1'b1,  0, 1'b0, b127,          1, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b1,   7, 1'b1,  7, 1'b0, b127 | b7,     2, 1'b0, 1'b0, 1};
        tbl[4]  = '{1'b0, 1'b1,   7, 1'b1,  7, 1'b0, b127 | b7,     2, 1'b0, 1'b0, 1};
        tbl[5]  = '{1'b0, 1'b1,   7, 1'b0,  0, 1'b0, b127 | b7,     2, 1'b1, 1'b0, 1};
        tbl[6]  = '{1'b0, 1'b0,   0, 1'b0,  0, 1'b0, b127 | b7,     2, 1'b0, 1'b0, 1};
        tbl[7]  = '{1'b0, 1'b1,   9, 1'b0,  0, 1'b1, b9,            1, 1'b0, 1'b0, 1};
        tbl[8]  = '{1'b0, 1'b1,   9, 1'b0,  0, 1'b0, b9,            1, 1'b1, 1'b0, 1};
        tbl[9]  = '{1'b0, 1'b0,   0, 1'b1, 50, 1'b0, b9,            1, 1'b0, 1'b0, 1};
        tbl[10] = '{1'b0, 1'b1, 100, 1'b1,  9, 1'b0, b100,          1, 1'b0, 1'b1, 0};

        // reset state
        step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        chk("reset_mask",  if128.mask_o, 128'h0);
        chk("reset_empty", 128'(if128.empty_o), 128'h1);

        // table-driven directed vectors
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].sv, tbl[i].si, tbl[i].cv, tbl[i].ci, tbl[i].ca);
            chk($sformatf("tbl%0d_mask", i),  if128.mask_o, tbl[i].e_mask);
            chk($sformatf("tbl%0d_cnt", i),   128'(if128.count_o), 128'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_dup", i),   128'(if128.dup_o), 128'(tbl[i].e_dup));
            chk($sformatf("tbl%0d_err100", i), 128'(if100.err_o), 128'(tbl[i].e_err100));
            chk($sformatf("tbl%0d_cnt100", i), 128'(if100.count_o), 128'(tbl[i].e_cnt100));
        end

        // clr_all over 0x0F with a set, then duplicate set lasts one cycle
        step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i, 1'b0, 0, 1'b0);
        chk("mask_0f", if128.mask_o, 128'hF);
        step(1'b0, 1'b1, 9, 1'b0, 0, 1'b1);
        chk("clrall_set_mask", if128.mask_o, 128'h200);
        chk("clrall_set_cnt",  128'(if128.count_o), 128'd1);
        step(1'b0, 1'b1, 9, 1'b0, 0, 1'b0);
        chk("dup_pulse", 128'(if128.dup_o), 128'h1);
        idle();
        chk("dup_cleared", 128'(if128.dup_o), 128'h0);

        // reset mid-operation overrides a concurrent set
        for (int i = 20; i < 25; i++) step(1'b0, 1'b1, i, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 3, 1'b0, 0, 1'b0);
        chk("midreset_mask",  if128.mask_o, 128'h0);
        chk("midreset_cnt",   128'(if128.count_o), 128'h0);
        chk("midreset_empty", 128'(if128.empty_o), 128'h1);

        // fill every index, then a set at full
        for (int i = 0; i < 128; i++) step(1'b0, 1'b1, i, 1'b0, 0, 1'b0);
        chk("full128", 128'(if128.full_o), 128'h1);
        chk("full100", 128'(if100.full_o), 128'h1);
        step(1'b0, 1'b1, 5, 1'b0, 0, 1'b0);
        chk("full_dup", 128'(if128.dup_o), 128'h1);
        chk("full_cnt", 128'(if128.count_o), 128'd128);

        // random traffic
        for (int c = 0; c < 10000; c++) begin
            step($urandom_range(0, 511) == 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 127)), $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 127)), $urandom_range(0, 63) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
